// File: rtl/spi_test_pkg.sv
// Shared constants for the SPI-controlled register block: register map,
// command byte layout and synchronizer depth.
package spi_test_pkg;

  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned CMD_W_BIT   = 7;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 5;

  localparam logic [ADDR_W-1:0] REG_OUT     = 3'd0;
  localparam logic [ADDR_W-1:0] REG_UIO_OUT = 3'd1;
  localparam logic [ADDR_W-1:0] REG_UIO_OE  = 3'd2;
  localparam logic [ADDR_W-1:0] REG_UIO_IN  = 3'd3;

  // Bit counter landmarks: last command bit, end of command byte, end of frame.
  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = 5'd7;
  localparam logic [CNT_W-1:0] CNT_CMD_DONE  = 5'd8;
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = 5'd15;
  localparam logic [CNT_W-1:0] CNT_DONE      = 5'd16;

endpackage

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled by the system clock: synchronizers, edge
// detection, 0..16 bit counter, command capture and RX/TX shift registers.
module spi_target
  import spi_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic [7:0]        rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              rd_load,
  output logic              miso
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic [ADDR_W-1:0]      cmd_addr_q, cmd_addr_d;
  logic                   cmd_wr_q, cmd_wr_d;
  logic                   rd_active_q, rd_active_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rd_load_q, rd_load_d;

  logic       sclk_s, cs_n_s, mosi_s;
  logic       sclk_rise, sclk_fall;
  logic [7:0] rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign rx_next   = {rx_q[6:0], mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_dly_d  = sclk_s;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wr_d    = cmd_wr_q;
    rd_active_d = rd_active_q;
    wr_en_d     = 1'b0;
    rd_load_d   = 1'b0;

    if (cs_n_s) begin
      cnt_d       = '0;
      rx_d        = '0;
      tx_d        = '0;
      rd_active_d = 1'b0;
    end else begin
      // rdata is presented by the top in the cycle rd_load is high.
      if (rd_load_q) begin
        tx_d        = rdata;
        rd_active_d = 1'b1;
      end
      if (sclk_rise && (cnt_q < CNT_DONE)) begin
        rx_d  = rx_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_CMD_LAST) begin
          cmd_wr_d   = rx_next[CMD_W_BIT];
          cmd_addr_d = rx_next[ADDR_W-1:0];
          rd_load_d  = ~rx_next[CMD_W_BIT];
        end
        if (cnt_q == CNT_DATA_LAST) wr_en_d = cmd_wr_q;
      end
      // The MSB must survive the falling edge that closes the command byte.
      if (sclk_fall && rd_active_q && (cnt_q > CNT_CMD_DONE))
        tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_addr_q  <= '0;
      cmd_wr_q    <= 1'b0;
      rd_active_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wr_q    <= cmd_wr_d;
      rd_active_q <= rd_active_d;
      wr_en_q     <= wr_en_d;
      rd_load_q   <= rd_load_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign addr    = cmd_addr_q;
  assign wdata   = rx_q;
  assign rd_load = rd_load_q;
  assign miso    = rd_active_q & tx_q[7] & ~cs_n_s;

endmodule

// File: rtl/mattvenn_spi_test.sv
// TinyTapeout tile top: eight SPI-accessible registers, three of which drive
// the dedicated outputs and bidirectional pins; REG3 reads back uio_in.
module mattvenn_spi_test
  import spi_test_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]                  regs_q [NUM_REGS];
  logic [7:0]                  regs_d [NUM_REGS];
  logic [SYNC_STAGES-1:0][7:0] uio_sync_q, uio_sync_d;

  logic              wr_en, rd_load, miso;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata, rdata;
  logic              unused;

  assign unused = &{1'b0, ena, ui_in[7:3]};

  spi_target u_spi_target (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclk    (ui_in[0]),
    .cs_n    (ui_in[1]),
    .mosi    (ui_in[2]),
    .rdata   (rdata),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rd_load (rd_load),
    .miso    (miso)
  );

  always_comb begin
    uio_sync_d = {uio_sync_q[SYNC_STAGES-2:0], uio_in};
    regs_d     = regs_q;
    if (wr_en && (addr != REG_UIO_IN)) regs_d[addr] = wdata;
  end

  always_comb begin
    rdata = '0;
    if (rd_load)
      rdata = (addr == REG_UIO_IN) ? uio_sync_q[SYNC_STAGES-1] : regs_q[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      uio_sync_q <= '0;
    end else begin
      regs_q     <= regs_d;
      uio_sync_q <= uio_sync_d;
    end
  end

  assign uo_out  = {miso, regs_q[REG_OUT][6:0]};
  assign uio_out = regs_q[REG_UIO_OUT];
  assign uio_oe  = regs_q[REG_UIO_OE];

endmodule

// File: tb/tb_mattvenn_spi_test.sv
// Directed bench for mattvenn_spi_test: table of SPI transactions with
// expected read data and pin states, plus abort and mid-frame reset sequences.
module tb_mattvenn_spi_test;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic sclk, cs_n, mosi;
  logic [7:0] snap3, snap4;

  int n_cmp  = 0;
  int n_fail = 0;

  assign ui_in = {5'b0, mosi, cs_n, sclk};

  always #5 clk = ~clk;

  mattvenn_spi_test dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] uio;
    logic [7:0] exp_rd;
    logic [7:0] exp_uo;
    logic [7:0] exp_out;
    logic [7:0] exp_oe;
  } vec_t;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Mode-0 controller: 4 clk per SCLK phase, MISO sampled just before each rise.
  task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                          output logic [7:0] rd, output logic miso_hi);
    logic [15:0] sh;
    sh      = {cmd, data};
    rd      = '0;
    miso_hi = 1'b0;
    cs_n    = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = sh[15-i];
      wait_clk(4);
      if (i >= 8) rd = {rd[6:0], uo_out[7]};
      miso_hi = miso_hi | uo_out[7];
      sclk = 1'b1;
      if (i == 15) begin
        wait_clk(3);
        snap3 = uo_out;
        wait_clk(1);
        snap4 = uo_out;
      end else begin
        wait_clk(4);
      end
      sclk = 1'b0;
    end
    wait_clk(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(6);
  endtask

  vec_t vecs[14];

  initial begin
    logic [7:0] rd;
    logic       mhi;
    logic [7:0] prev_uo;

    vecs[0]  = '{8'h80, 8'h55, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00};
    vecs[1]  = '{8'h82, 8'hF0, 8'h00, 8'h00, 8'h55, 8'h00, 8'hF0};
    vecs[2]  = '{8'h81, 8'hA5, 8'h00, 8'h00, 8'h55, 8'hA5, 8'hF0};
    vecs[3]  = '{8'h01, 8'h00, 8'h00, 8'hA5, 8'h55, 8'hA5, 8'hF0};
    vecs[4]  = '{8'h03, 8'h00, 8'h3C, 8'h3C, 8'h55, 8'hA5, 8'hF0};
    vecs[5]  = '{8'h83, 8'hFF, 8'h3C, 8'h00, 8'h55, 8'hA5, 8'hF0};
    vecs[6]  = '{8'h03, 8'h00, 8'h3C, 8'h3C, 8'h55, 8'hA5, 8'hF0};
    vecs[7]  = '{8'h86, 8'hC3, 8'h3C, 8'h00, 8'h55, 8'hA5, 8'hF0};
    vecs[8]  = '{8'h06, 8'h00, 8'h3C, 8'hC3, 8'h55, 8'hA5, 8'hF0};
    vecs[9]  = '{8'h07, 8'h00, 8'h3C, 8'h00, 8'h55, 8'hA5, 8'hF0};
    vecs[10] = '{8'h80, 8'hAA, 8'h3C, 8'h00, 8'h2A, 8'hA5, 8'hF0};
    vecs[11] = '{8'h00, 8'h00, 8'h3C, 8'hAA, 8'h2A, 8'hA5, 8'hF0};
    vecs[12] = '{8'h7E, 8'h00, 8'h3C, 8'hC3, 8'h2A, 8'hA5, 8'hF0};
    vecs[13] = '{8'hF9, 8'h3C, 8'h3C, 8'h00, 8'h2A, 8'h3C, 8'hF0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    sclk   = 1'b0;
    cs_n   = 1'b1;
    mosi   = 1'b0;
    uio_in = 8'h00;
    snap3  = '0;
    snap4  = '0;

    wait_clk(4);
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    wait_clk(5);
    check("post_reset_uo_out", uo_out, 8'h00);

    prev_uo = 8'h00;
    for (int v = 0; v < 14; v++) begin
      uio_in = vecs[v].uio;
      spi_xfer(vecs[v].cmd, vecs[v].data, 16, rd, mhi);
      if (vecs[v].cmd[7]) check($sformatf("v%0d_write_miso_low", v), {7'b0, mhi}, 8'h00);
      else                check($sformatf("v%0d_read_data", v), rd, vecs[v].exp_rd);
      check($sformatf("v%0d_uo_before_4th_clk", v), {1'b0, snap3[6:0]}, {1'b0, prev_uo[6:0]});
      check($sformatf("v%0d_uo_at_4th_clk", v), {1'b0, snap4[6:0]}, {1'b0, vecs[v].exp_uo[6:0]});
      check($sformatf("v%0d_uo_out", v), uo_out, vecs[v].exp_uo);
      check($sformatf("v%0d_uio_out", v), uio_out, vecs[v].exp_out);
      check($sformatf("v%0d_uio_oe", v), uio_oe, vecs[v].exp_oe);
      prev_uo = vecs[v].exp_uo;
    end

    // Abort: write REG1 with only 4 data bits, then a complete write.
    spi_xfer(8'h81, 8'hFF, 12, rd, mhi);
    check("abort_uio_out", uio_out, 8'h3C);
    check("abort_miso_idle", {7'b0, uo_out[7]}, 8'h00);
    spi_xfer(8'h81, 8'h12, 16, rd, mhi);
    check("after_abort_uio_out", uio_out, 8'h12);

    // Asynchronous reset in the middle of a write frame.
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_uo_out", uo_out, 8'h00);
    check("midreset_uio_out", uio_out, 8'h00);
    check("midreset_uio_oe", uio_oe, 8'h00);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    spi_xfer(8'h06, 8'h00, 16, rd, mhi);
    check("midreset_reg6_cleared", rd, 8'h00);
    spi_xfer(8'h86, 8'h11, 16, rd, mhi);
    spi_xfer(8'h06, 8'h00, 16, rd, mhi);
    check("midreset_reg6_rewrite", rd, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
